// File: rtl/lms_weight_bank.sv
//------------------------------------------------------------------------------
// Module   : lms_weight_bank
// Purpose  : Coefficient register bank and adaptation sequencer for an 8-tap
//            LMS adaptive filter. Holds W1..W8, captures updated weights
//            N1..N8 from the weight-update adder under a valid/ready
//            handshake, counts accepted iterations and stops adapting once
//            a programmable iteration budget has been used up.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            start               - pulse: clear iteration count, enter ADAPT
//            freeze              - level: block update capture
//            iter_max            - iteration budget (0 = unlimited)
//            ld_en/ld_sel/ld_data- single-tap coefficient preload
//            upd_valid/upd_ready - handshake for N1..N8
//            N1..N8              - updated weights from adder block
//            W1..W8              - registered current weights
//            w_valid             - pulse after an accepted update
//            iter_cnt            - accepted updates since last start
//            done                - iteration budget exhausted
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lms_weight_bank #(
  parameter int WIDTH  = 10,
  parameter int ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              freeze,
  input  logic [ITER_W-1:0] iter_max,
  input  logic              ld_en,
  input  logic [2:0]        ld_sel,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [WIDTH-1:0]  N1,
  input  logic [WIDTH-1:0]  N2,
  input  logic [WIDTH-1:0]  N3,
  input  logic [WIDTH-1:0]  N4,
  input  logic [WIDTH-1:0]  N5,
  input  logic [WIDTH-1:0]  N6,
  input  logic [WIDTH-1:0]  N7,
  input  logic [WIDTH-1:0]  N8,
  output logic [WIDTH-1:0]  W1,
  output logic [WIDTH-1:0]  W2,
  output logic [WIDTH-1:0]  W3,
  output logic [WIDTH-1:0]  W4,
  output logic [WIDTH-1:0]  W5,
  output logic [WIDTH-1:0]  W6,
  output logic [WIDTH-1:0]  W7,
  output logic [WIDTH-1:0]  W8,
  output logic              w_valid,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADAPT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ITER_W-1:0] C_CNT_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
  localparam logic [ITER_W-1:0] C_CNT_ZERO = '0;

  state_t            r_state;
  logic [WIDTH-1:0]  r_w [8];
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_w_valid;

  logic [WIDTH-1:0]  w_n [8];
  logic              w_fire;
  logic [ITER_W-1:0] w_cnt_inc;

  assign w_n[0] = N1;
  assign w_n[1] = N2;
  assign w_n[2] = N3;
  assign w_n[3] = N4;
  assign w_n[4] = N5;
  assign w_n[5] = N6;
  assign w_n[6] = N7;
  assign w_n[7] = N8;

  // Start and preload both take priority over a capture, so ready drops in
  // those cycles; upd_valid never feeds back into ready.
  assign upd_ready = (r_state == S_ADAPT) && !freeze && !ld_en && !start;
  assign w_fire    = upd_valid && upd_ready;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_cnt_inc = (&r_iter_cnt) ? r_iter_cnt : (r_iter_cnt + C_CNT_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_iter_cnt <= C_CNT_ZERO;
      r_w_valid  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        r_w[i] <= '0;
      end
    end else begin
      r_w_valid <= 1'b0;

      // Preload never coincides with a capture because ready is low then.
      if (ld_en) begin
        r_w[ld_sel] <= ld_data;
      end

      if (start) begin
        r_iter_cnt <= C_CNT_ZERO;
        r_state    <= S_ADAPT;
      end else if (w_fire) begin
        for (int i = 0; i < 8; i++) begin
          r_w[i] <= w_n[i];
        end
        r_w_valid  <= 1'b1;
        r_iter_cnt <= w_cnt_inc;
        if ((iter_max != C_CNT_ZERO) && (w_cnt_inc == iter_max)) begin
          r_state <= S_DONE;
        end
      end
    end
  end

  assign W1       = r_w[0];
  assign W2       = r_w[1];
  assign W3       = r_w[2];
  assign W4       = r_w[3];
  assign W5       = r_w[4];
  assign W6       = r_w[5];
  assign W7       = r_w[6];
  assign W8       = r_w[7];
  assign w_valid  = r_w_valid;
  assign iter_cnt = r_iter_cnt;
  assign done     = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_lms_weight_bank.sv
//------------------------------------------------------------------------------
// Module   : tb_lms_weight_bank
// Purpose  : Directed self-checking bench for lms_weight_bank. A 16-bit
//            counter instance covers the main sequencing; a 4-bit counter
//            instance covers counter saturation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lms_weight_bank;

  localparam int WIDTH = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, freeze, ld_en, upd_valid;
  logic [15:0]       iter_max;
  logic [2:0]        ld_sel;
  logic [WIDTH-1:0]  ld_data;
  logic [WIDTH-1:0]  n [8];
  logic              upd_ready, w_valid, done;
  logic [WIDTH-1:0]  w [8];
  logic [15:0]       iter_cnt;

  // Saturation instance
  logic              start4, upd_valid4;
  logic              upd_ready4, w_valid4, done4;
  logic [WIDTH-1:0]  w4 [8];
  logic [3:0]        iter_cnt4;
  logic [3:0]        iter_max4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lms_weight_bank #(.WIDTH(WIDTH), .ITER_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .freeze(freeze), .iter_max(iter_max),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_data(ld_data),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .N1(n[0]), .N2(n[1]), .N3(n[2]), .N4(n[3]),
    .N5(n[4]), .N6(n[5]), .N7(n[6]), .N8(n[7]),
    .W1(w[0]), .W2(w[1]), .W3(w[2]), .W4(w[3]),
    .W5(w[4]), .W6(w[5]), .W7(w[6]), .W8(w[7]),
    .w_valid(w_valid), .iter_cnt(iter_cnt), .done(done)
  );

  lms_weight_bank #(.WIDTH(WIDTH), .ITER_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .freeze(1'b0), .iter_max(iter_max4),
    .ld_en(1'b0), .ld_sel(3'd0), .ld_data(ld_data),
    .upd_valid(upd_valid4), .upd_ready(upd_ready4),
    .N1(n[0]), .N2(n[1]), .N3(n[2]), .N4(n[3]),
    .N5(n[4]), .N6(n[5]), .N7(n[6]), .N8(n[7]),
    .W1(w4[0]), .W2(w4[1]), .W3(w4[2]), .W4(w4[3]),
    .W5(w4[4]), .W6(w4[5]), .W7(w4[6]), .W8(w4[7]),
    .w_valid(w_valid4), .iter_cnt(iter_cnt4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Set N_tap = k*16 + tap (tap = 1..8).
  task automatic set_n(input int k);
    for (int t = 0; t < 8; t++) begin
      n[t] = WIDTH'(k * 16 + t + 1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; freeze = 1'b0; ld_en = 1'b0; upd_valid = 1'b0;
    iter_max = 16'd0; ld_sel = 3'd0; ld_data = '0;
    start4 = 1'b0; upd_valid4 = 1'b0; iter_max4 = 4'd0;
    set_n(0);
    #12;
    // Reset values
    chk("rst_W1", 32'(w[0]), 32'h0);
    chk("rst_W8", 32'(w[7]), 32'h0);
    chk("rst_iter_cnt", 32'(iter_cnt), 32'h0);
    chk("rst_upd_ready", 32'(upd_ready), 32'h0);
    chk("rst_w_valid", 32'(w_valid), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    // IDLE ignores upd_valid
    set_n(9);
    upd_valid = 1'b1;
    #1 chk("idle_ready", 32'(upd_ready), 32'h0);
    step();
    chk("idle_W1", 32'(w[0]), 32'h0);
    chk("idle_w_valid", 32'(w_valid), 32'h0);

    // Start with budget 3; start suppresses ready
    upd_valid = 1'b0;
    start = 1'b1; iter_max = 16'd3;
    #1 chk("start_ready", 32'(upd_ready), 32'h0);
    step();
    start = 1'b0;
    chk("start_cnt", 32'(iter_cnt), 32'h0);
    chk("start_done", 32'(done), 32'h0);

    // Three captures: N_k = k*16+tap
    for (int k = 1; k <= 3; k++) begin
      set_n(k);
      upd_valid = 1'b1;
      #1 chk("adapt_ready", 32'(upd_ready), 32'h1);
      step();
      chk("cap_W1", 32'(w[0]), 32'(k * 16 + 1));
      chk("cap_W8", 32'(w[7]), 32'(k * 16 + 8));
      chk("cap_w_valid", 32'(w_valid), 32'h1);
      chk("cap_cnt", 32'(iter_cnt), 32'(k));
    end
    chk("budget_W1", 32'(w[0]), 32'h031);
    chk("budget_done", 32'(done), 32'h1);
    chk("budget_ready", 32'(upd_ready), 32'h0);
    set_n(4);
    step();
    chk("done_hold_W1", 32'(w[0]), 32'h031);
    chk("done_hold_cnt", 32'(iter_cnt), 32'h3);
    chk("done_w_valid", 32'(w_valid), 32'h0);

    // Restart, unlimited budget
    upd_valid = 1'b0;
    start = 1'b1; iter_max = 16'd0;
    step();
    start = 1'b0;
    chk("restart_done", 32'(done), 32'h0);
    chk("restart_cnt", 32'(iter_cnt), 32'h0);

    // Freeze for 5 cycles with valid held
    freeze = 1'b1; upd_valid = 1'b1; set_n(4);
    for (int c = 0; c < 5; c++) begin
      #1 chk("frz_ready", 32'(upd_ready), 32'h0);
      step();
      chk("frz_W1", 32'(w[0]), 32'h031);
      chk("frz_cnt", 32'(iter_cnt), 32'h0);
      chk("frz_w_valid", 32'(w_valid), 32'h0);
    end
    freeze = 1'b0;
    #1 chk("unfrz_ready", 32'(upd_ready), 32'h1);
    step();
    chk("unfrz_W1", 32'(w[0]), 32'h041);
    chk("unfrz_w_valid", 32'(w_valid), 32'h1);
    chk("unfrz_cnt", 32'(iter_cnt), 32'h1);

    // Preload W6 colliding with a valid update
    set_n(5);
    ld_en = 1'b1; ld_sel = 3'd5; ld_data = 10'h3FF;
    #1 chk("ld_ready", 32'(upd_ready), 32'h0);
    step();
    ld_en = 1'b0;
    chk("ld_W6", 32'(w[5]), 32'h3FF);
    chk("ld_W1", 32'(w[0]), 32'h041);
    chk("ld_w_valid", 32'(w_valid), 32'h0);
    chk("ld_cnt", 32'(iter_cnt), 32'h1);
    step();
    chk("postld_W1", 32'(w[0]), 32'h051);
    chk("postld_W6", 32'(w[5]), 32'h056);
    chk("postld_w_valid", 32'(w_valid), 32'h1);
    chk("postld_cnt", 32'(iter_cnt), 32'h2);

    // Five more captures -> 7 total
    for (int k = 6; k <= 10; k++) begin
      set_n(k);
      step();
    end
    chk("seven_cnt", 32'(iter_cnt), 32'h7);
    chk("seven_W1", 32'(w[0]), 32'h0A1);

    // Start coincident with valid: start wins, capture discarded
    set_n(11);
    start = 1'b1;
    #1 chk("sv_ready", 32'(upd_ready), 32'h0);
    step();
    start = 1'b0;
    chk("sv_cnt", 32'(iter_cnt), 32'h0);
    chk("sv_W1", 32'(w[0]), 32'h0A1);
    chk("sv_w_valid", 32'(w_valid), 32'h0);
    chk("sv_done", 32'(done), 32'h0);

    // Asynchronous reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("arst_W1", 32'(w[0]), 32'h0);
    chk("arst_W6", 32'(w[5]), 32'h0);
    chk("arst_cnt", 32'(iter_cnt), 32'h0);
    chk("arst_ready", 32'(upd_ready), 32'h0);
    step();
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(upd_ready), 32'h0);
    step();
    chk("post_rst_W1", 32'(w[0]), 32'h0);
    chk("post_rst_cnt", 32'(iter_cnt), 32'h0);
    upd_valid = 1'b0;

    // Saturation on 4-bit counter, unlimited budget
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    upd_valid4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      for (int t = 0; t < 8; t++) n[t] = WIDTH'(i * 8 + t);
      step();
      chk("sat_cnt", 32'(iter_cnt4), 32'((i > 15) ? 15 : i));
      chk("sat_W1", 32'(w4[0]), 32'(i * 8));
    end
    chk("sat_w_valid", 32'(w_valid4), 32'h1);
    chk("sat_done", 32'(done4), 32'h0);
    #1 chk("sat_ready", 32'(upd_ready4), 32'h1);
    upd_valid4 = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
